// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR run controller: FSM state encoding,
// default widths, synchroniser lane indices and the prescaler terminal count.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;
  localparam int PRESCALE_W = 16;

  // Lane order of the three synchronised pins
  localparam int SYNC_RUN  = 0;
  localparam int SYNC_STEP = 1;
  localparam int SYNC_LOAD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Terminal count for a step period of 2^(2*sel+2) cycles (4 .. 65536)
  function automatic logic [PRESCALE_W-1:0] div_tc(input logic [2:0] sel);
    logic [PRESCALE_W:0] period;
    period = (PRESCALE_W+1)'(1) << ({2'b00, sel, 1'b0} + 6'd2);
    return PRESCALE_W'(period - (PRESCALE_W+1)'(1));
  endfunction

endpackage

// File: rtl/lfsr_run_ctrl_sync.sv
// Two-flop synchroniser for one asynchronous pin, plus a rising-edge pulse
// derived from the synchronised level. Everything freezes while ena is low.
module in_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Shift the pin through the synchroniser and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else if (ena) begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  // Pulse is combinational so the FSM can register its strobe on the next edge
  assign rise  = ena & sync_reg & ~prev_reg;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Sequencer for the LFSR datapath: seeds the core, steps it at a programmable
// rate or from a button, and captures each new LFSR state for the display.
module lfsr_run_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH      = lfsr_pkg::LFSR_WIDTH,
  parameter int PRESCALE_W = lfsr_pkg::PRESCALE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             run_i,
  input  logic             step_btn_i,
  input  logic             load_i,
  input  logic [2:0]       div_sel_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] lfsr_q_i,
  output logic             lfsr_load_o,
  output logic [WIDTH-1:0] lfsr_seed_o,
  output logic             lfsr_step_o,
  output logic [WIDTH-1:0] disp_val_o,
  output logic             disp_upd_o,
  output logic [1:0]       state_o
);

  logic [2:0] pin_bus;
  logic [2:0] level_bus;
  logic [2:0] rise_bus;
  logic       sync_unused;

  logic run_sync;
  logic step_rise;
  logic load_rise;

  state_t                state_reg;
  logic [WIDTH-1:0]      seed_reg;
  logic                  load_reg;
  logic                  step_reg;
  logic [PRESCALE_W-1:0] count_reg;
  logic                  cap_reg;
  logic [WIDTH-1:0]      disp_reg;
  logic                  upd_reg;

  logic [PRESCALE_W-1:0] tc;
  logic [PRESCALE_W-1:0] count_inc;
  logic [WIDTH-1:0]      seed_fix;

  assign pin_bus = {load_i, step_btn_i, run_i};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      in_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (pin_bus[gi]),
        .level (level_bus[gi]),
        .rise  (rise_bus[gi])
      );
    end
  endgenerate

  assign run_sync  = level_bus[SYNC_RUN];
  assign step_rise = rise_bus[SYNC_STEP];
  assign load_rise = rise_bus[SYNC_LOAD];
  // Lanes whose level or edge the sequencer has no use for
  assign sync_unused = ^{level_bus[SYNC_STEP], level_bus[SYNC_LOAD], rise_bus[SYNC_RUN]};

  // Terminal count tracks div_sel_i every cycle; a zero seed would lock the LFSR, so it becomes 1
  always_comb begin
    tc        = PRESCALE_W'(div_tc(div_sel_i));
    count_inc = count_reg + PRESCALE_W'(1);
    seed_fix  = (seed_i == '0) ? WIDTH'(1) : seed_i;
  end

  // Sequencer FSM with prescaler; strobes are registered and land in the cycle the count equals TC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      seed_reg  <= WIDTH'(1);
      load_reg  <= 1'b0;
      step_reg  <= 1'b0;
      count_reg <= '0;
    end else if (ena) begin
      load_reg <= 1'b0;
      step_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (load_rise) begin
            state_reg <= LOAD;
            load_reg  <= 1'b1;
            seed_reg  <= seed_fix;
          end
        end
        LOAD: begin
          count_reg <= '0;
          state_reg <= run_sync ? RUN : PAUSE;
        end
        RUN: begin
          if (load_rise) begin
            // A load replaces any step that was about to be issued
            state_reg <= LOAD;
            load_reg  <= 1'b1;
            seed_reg  <= seed_fix;
            count_reg <= '0;
          end else if (!run_sync) begin
            state_reg <= PAUSE;
            count_reg <= '0;
          end else if (count_reg >= tc) begin
            // Wrap after TC, or a rate change left the count past the new TC: restart silently
            count_reg <= '0;
          end else begin
            count_reg <= count_inc;
            step_reg  <= (count_inc == tc);
          end
        end
        PAUSE: begin
          count_reg <= '0;
          if (load_rise) begin
            state_reg <= LOAD;
            load_reg  <= 1'b1;
            seed_reg  <= seed_fix;
          end else if (run_sync) begin
            state_reg <= RUN;
          end else if (step_rise) begin
            step_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  // Capture the core output on the cycle after a strobe, once the core has updated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg  <= 1'b0;
      disp_reg <= '0;
      upd_reg  <= 1'b0;
    end else if (ena) begin
      cap_reg <= load_reg | step_reg;
      upd_reg <= cap_reg;
      if (cap_reg) begin
        disp_reg <= lfsr_q_i;
      end
    end
  end

  // Strobes are silenced while the design is deselected; the registers behind them hold
  assign lfsr_load_o = load_reg & ena;
  assign lfsr_step_o = step_reg & ena;
  assign disp_upd_o  = upd_reg & ena;
  assign lfsr_seed_o = seed_reg;
  assign disp_val_o  = disp_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl: a cycle-level reference model of the sequencing
// rules checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_lfsr_run_ctrl;

  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_RUN   = 2;
  localparam int ST_PAUSE = 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       run_i;
  logic       step_btn_i;
  logic       load_i;
  logic [2:0] div_sel_i;
  logic [7:0] seed_i;
  logic [7:0] lfsr_q_i;
  logic       lfsr_load_o;
  logic [7:0] lfsr_seed_o;
  logic       lfsr_step_o;
  logic [7:0] disp_val_o;
  logic       disp_upd_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int n_step = 0;
  int n_load = 0;

  lfsr_run_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .run_i       (run_i),
    .step_btn_i  (step_btn_i),
    .load_i      (load_i),
    .div_sel_i   (div_sel_i),
    .seed_i      (seed_i),
    .lfsr_q_i    (lfsr_q_i),
    .lfsr_load_o (lfsr_load_o),
    .lfsr_seed_o (lfsr_seed_o),
    .lfsr_step_o (lfsr_step_o),
    .disp_val_o  (disp_val_o),
    .disp_upd_o  (disp_upd_o),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // LFSR core stand-in driven by the DUT strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q_i <= 8'h00;
    else if (lfsr_load_o) lfsr_q_i <= lfsr_seed_o;
    else if (lfsr_step_o) lfsr_q_i <= lfsr_next(lfsr_q_i);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  int       m_state = ST_IDLE;
  int       m_seed  = 1;
  int       m_load  = 0;
  int       m_step  = 0;
  int       m_cnt   = 0;
  int       m_cap   = 0;
  int       m_upd   = 0;
  int       m_disp  = 0;
  int       m_core  = 0;
  bit [2:0] h_run   = '0;
  bit [2:0] h_step  = '0;
  bit [2:0] h_load  = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = ST_IDLE; m_seed = 1; m_load = 0; m_step = 0; m_cnt = 0;
        m_cap = 0; m_upd = 0; m_disp = 0; m_core = 0;
        h_run = '0; h_step = '0; h_load = '0;
      end else if (ena) begin
        bit ev_load, ev_step, lvl_run;
        int period;
        // display follows the core one cycle after the core moved
        if (m_cap != 0) m_disp = m_core;
        m_upd = m_cap;
        m_cap = m_load | m_step;
        if (m_load != 0) m_core = m_seed;
        else if (m_step != 0) m_core = int'(lfsr_next(8'(m_core)));
        // pins are seen two cycles late; an edge is a 0->1 of the delayed level
        ev_load = h_load[1] && !h_load[2];
        ev_step = h_step[1] && !h_step[2];
        lvl_run = h_run[1];
        period  = 1 << (2 * int'(div_sel_i) + 2);
        m_load = 0;
        m_step = 0;
        if (m_state == ST_LOAD) begin
          m_cnt   = 0;
          m_state = lvl_run ? ST_RUN : ST_PAUSE;
        end else if (m_state != ST_IDLE && ev_load || m_state == ST_IDLE && ev_load) begin
          m_state = ST_LOAD;
          m_load  = 1;
          m_seed  = (seed_i == 8'h00) ? 1 : int'(seed_i);
          m_cnt   = 0;
        end else if (m_state == ST_RUN && !lvl_run) begin
          m_state = ST_PAUSE;
          m_cnt   = 0;
        end else if (m_state == ST_PAUSE && lvl_run) begin
          m_state = ST_RUN;
          m_cnt   = 0;
        end else if (m_state == ST_PAUSE) begin
          m_step = ev_step ? 1 : 0;
        end else if (m_state == ST_RUN) begin
          if (m_cnt >= period - 1) m_cnt = 0;
          else begin
            m_cnt  = m_cnt + 1;
            m_step = (m_cnt == period - 1) ? 1 : 0;
          end
        end
        h_run  = {h_run[1:0], run_i};
        h_step = {h_step[1:0], step_btn_i};
        h_load = {h_load[1:0], load_i};
      end
    end
  end

  // Compare DUT against the model away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("state", 32'(state_o), 32'(m_state));
      chk("load_strobe", 32'(lfsr_load_o), 32'(m_load & int'(ena)));
      chk("step_strobe", 32'(lfsr_step_o), 32'(m_step & int'(ena)));
      chk("seed", 32'(lfsr_seed_o), 32'(m_seed));
      chk("disp_val", 32'(disp_val_o), 32'(m_disp));
      chk("disp_upd", 32'(disp_upd_o), 32'(m_upd & int'(ena)));
      if (lfsr_step_o) n_step++;
      if (lfsr_load_o) n_load++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_upd(input int max_cyc, input logic [7:0] want, input string name);
    bit seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk); #1;
      if (disp_upd_o) seen = 1;
    end
    if (seen) chk(name, 32'(disp_val_o), 32'(want));
    else timeout(name);
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc, input string name);
    bit seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk); #1;
      if (state_o == st) seen = 1;
    end
    if (!seen) timeout(name);
  endtask

  task automatic cycles_to_step(input int max_cyc, output int k);
    k = -1;
    for (int i = 1; i <= max_cyc && k < 0; i++) begin
      @(negedge clk); #1;
      if (lfsr_step_o) k = i;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    rst_n = 1'b0; ena = 1'b1; run_i = 1'b0; step_btn_i = 1'b0; load_i = 1'b0;
    div_sel_i = 3'd0; seed_i = 8'h00;
    cyc(3);
    chk("reset_state", 32'(state_o), 32'(ST_IDLE));
    chk("reset_seed", 32'(lfsr_seed_o), 32'h01);
    chk("reset_strobes", 32'({lfsr_load_o, lfsr_step_o, disp_upd_o}), 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // 1: zero seed is replaced by 1, run low -> PAUSE
    n0 = n_load;
    load_i = 1'b1; seed_i = 8'h00;
    cyc(10);
    load_i = 1'b0;
    cyc(5);
    chk("t1_load_count", 32'(n_load - n0), 32'd1);
    chk("t1_seed", 32'(lfsr_seed_o), 32'h01);
    chk("t1_state", 32'(state_o), 32'(ST_PAUSE));
    chk("t1_disp", 32'(disp_val_o), 32'h01);

    // 2: seed A5, free-run at period 4; a step press in RUN is ignored
    seed_i = 8'hA5; div_sel_i = 3'd0; load_i = 1'b1; run_i = 1'b1;
    wait_upd(20, 8'hA5, "t2_disp_seed");
    wait_upd(20, 8'h4A, "t2_disp_step1");
    wait_upd(20, 8'h95, "t2_disp_step2");
    load_i = 1'b0;
    n0 = n_step;
    cyc(10);
    step_btn_i = 1'b1;
    cyc(10);
    step_btn_i = 1'b0;
    cyc(20);
    chk("t2_steps_in_40", 32'(n_step - n0), 32'd10);

    // 3: single-step from PAUSE
    run_i = 1'b0;
    cyc(10);
    chk("t3_state", 32'(state_o), 32'(ST_PAUSE));
    n0 = n_step;
    for (int p = 0; p < 3; p++) begin
      step_btn_i = 1'b1; cyc(10);
      step_btn_i = 1'b0; cyc(10);
    end
    chk("t3_three_pulses", 32'(n_step - n0), 32'd3);
    n0 = n_step;
    step_btn_i = 1'b1; cyc(1000);
    step_btn_i = 1'b0; cyc(10);
    chk("t3_long_hold", 32'(n_step - n0), 32'd1);

    // 4: rate change at count 100 clears the prescaler without a strobe
    div_sel_i = 3'd3; run_i = 1'b1;
    wait_state(2'(ST_RUN), 20, "t4_enter_run");
    cyc(100);
    div_sel_i = 3'd0;
    cycles_to_step(20, k);
    chk("t4_after_clear", 32'(k), 32'd4);
    cycles_to_step(20, k);
    chk("t4_period", 32'(k), 32'd4);

    // 5: load edge lands on the TC cycle -> load only, then RUN
    cycles_to_step(20, k);
    cyc(1);
    seed_i = 8'h3C; load_i = 1'b1;
    cyc(3);
    chk("t5_load", 32'(lfsr_load_o), 32'd1);
    chk("t5_no_step", 32'(lfsr_step_o), 32'd0);
    chk("t5_state_load", 32'(state_o), 32'(ST_LOAD));
    chk("t5_seed", 32'(lfsr_seed_o), 32'h3C);
    cyc(1);
    chk("t5_state_run", 32'(state_o), 32'(ST_RUN));
    load_i = 1'b0;

    // 6: ena low freezes the prescaler; strobe resumes at the remaining count
    div_sel_i = 3'd1;
    cycles_to_step(40, k);
    cyc(5);
    ena = 1'b0;
    n0 = n_step;
    cyc(50);
    chk("t6_frozen_steps", 32'(n_step - n0), 32'd0);
    ena = 1'b1;
    cycles_to_step(40, k);
    chk("t6_resume", 32'(k), 32'd11);

    // async reset mid-RUN
    cyc(7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_seed", 32'(lfsr_seed_o), 32'h01);
    chk("rst_outputs", 32'({lfsr_load_o, lfsr_step_o, disp_upd_o, disp_val_o}), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    n0 = n_step;
    cyc(30);
    chk("rst_stays_idle", 32'(state_o), 32'(ST_IDLE));
    chk("rst_no_steps", 32'(n_step - n0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
